// File: rtl/tx_fifo_scheduler.sv
// Burst scheduler that drains a byte FIFO into a UART transmitter.
// A burst starts on a fill-level threshold or an idle timeout and paces bytes with a gap.
module tx_fifo_scheduler #(
  parameter logic [15:0] THRESHOLD      = 16'd8,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
  parameter logic [15:0] GAP_CYCLES     = 16'd2,
  parameter logic [7:0]  ACK_CYCLES     = 8'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        n_clr_i,
  input  logic        enable_i,
  input  logic [7:0]  fifo_data_i,
  input  logic        fifo_empty_i,
  input  logic [15:0] fifo_bytes_i,
  input  logic        tx_busy_i,
  output logic        fifo_n_re_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  output logic        p_burst_o,
  output logic        p_txerr_o,
  output logic [15:0] burst_count_o
);

  typedef enum logic [2:0] {
    IDLE, READ, LATCH, SEND, WAIT_ACK, WAIT_DONE, GAP
  } state_t;

  state_t      state;
  logic [15:0] idle_cnt;
  logic [15:0] gap_cnt;
  logic [15:0] ack_cnt;
  logic [1:0]  rst_sync;
  logic        rst_int;
  logic        trigger;
  logic        more_data;
  logic        gap_last;
  logic        ack_last;

  // Reset asserts asynchronously but is released two clocks later, aligned to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int = rst_sync[1];

  assign trigger   = enable_i && !fifo_empty_i &&
                     ((fifo_bytes_i >= THRESHOLD) || (idle_cnt == TIMEOUT_CYCLES));
  assign more_data = enable_i && !fifo_empty_i;
  // GAP_CYCLES of zero still spends one cycle in GAP.
  assign gap_last  = ({1'b0, gap_cnt} + 17'd1) >= {1'b0, GAP_CYCLES};
  assign ack_last  = ({1'b0, ack_cnt} + 17'd1) >= {9'd0, ACK_CYCLES};

  // NOTE: tx_start_o is decoded combinationally so the pulse lands in the very cycle
  // busy is seen low in SEND, and is suppressed by a clear arriving in that cycle.
  assign tx_start_o = (state == SEND) && !tx_busy_i && n_clr_i;

  // NOTE: all state below uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      state         <= IDLE;
      fifo_n_re_o   <= 1'b1;
      tx_data_o     <= 8'h00;
      p_burst_o     <= 1'b0;
      p_txerr_o     <= 1'b0;
      burst_count_o <= '0;
      idle_cnt      <= '0;
      gap_cnt       <= '0;
      ack_cnt       <= '0;
    end else if (!n_clr_i) begin
      state         <= IDLE;
      fifo_n_re_o   <= 1'b1;
      tx_data_o     <= 8'h00;
      p_burst_o     <= 1'b0;
      p_txerr_o     <= 1'b0;
      burst_count_o <= '0;
      idle_cnt      <= '0;
      gap_cnt       <= '0;
      ack_cnt       <= '0;
    end else begin
      fifo_n_re_o <= 1'b1;
      case (state)
        IDLE: begin
          if (trigger) begin
            state         <= READ;
            fifo_n_re_o   <= 1'b0;
            p_burst_o     <= 1'b1;
            idle_cnt      <= '0;
            burst_count_o <= '0;
          end else if (fifo_empty_i) begin
            idle_cnt <= '0;
          end else if (idle_cnt < TIMEOUT_CYCLES) begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
        READ: state <= LATCH;
        LATCH: begin
          tx_data_o <= fifo_data_i;
          state     <= SEND;
        end
        SEND: begin
          if (!tx_busy_i) begin
            state   <= WAIT_ACK;
            ack_cnt <= '0;
            if (burst_count_o != 16'hFFFF) burst_count_o <= burst_count_o + 16'd1;
          end
        end
        WAIT_ACK: begin
          // A transmitter that never acknowledges drops the byte; it is not retried.
          if (tx_busy_i) begin
            state <= WAIT_DONE;
          end else if (ack_last) begin
            state     <= IDLE;
            p_burst_o <= 1'b0;
            p_txerr_o <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + 16'd1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_last) begin
            if (more_data) begin
              state       <= READ;
              fifo_n_re_o <= 1'b0;
            end else begin
              state     <= IDLE;
              p_burst_o <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: begin
          state     <= IDLE;
          p_burst_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_fifo_scheduler.sv
// Self-checking bench for tx_fifo_scheduler: FIFO and UART models, a byte scoreboard,
// a table of burst scenarios and hand-written clear/reset sequences.
module tb_tx_fifo_scheduler;

  localparam int GAP = 2;
  localparam int ACK = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        n_clr_i = 1'b1;
  logic        enable_i = 1'b1;
  logic [7:0]  fifo_data_i = 8'h00;
  logic        fifo_empty_i = 1'b1;
  logic [15:0] fifo_bytes_i = 16'd0;
  logic        tx_busy_i = 1'b0;
  logic        fifo_n_re_o;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        p_burst_o;
  logic        p_txerr_o;
  logic [15:0] burst_count_o;

  tx_fifo_scheduler #(
    .THRESHOLD(16'd8), .TIMEOUT_CYCLES(16'd10), .GAP_CYCLES(16'd2), .ACK_CYCLES(8'd8)
  ) dut (
    .clk(clk), .rst(rst), .n_clr_i(n_clr_i), .enable_i(enable_i),
    .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i), .fifo_bytes_i(fifo_bytes_i),
    .tx_busy_i(tx_busy_i), .fifo_n_re_o(fifo_n_re_o), .tx_data_o(tx_data_o),
    .tx_start_o(tx_start_o), .p_burst_o(p_burst_o), .p_txerr_o(p_txerr_o),
    .burst_count_o(burst_count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int n_bytes;
    int busy_len;
    bit stuck;
    bit drop;
    int lat;
    int starts;
    int count;
    int err;
    int left;
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  int busy_len = 1;
  int busy_left = 0;
  bit model_busy = 1'b0;
  bit rise_pend = 1'b0;
  bit busy_hold = 1'b0;
  bit stuck = 1'b0;
  bit drop_arm = 1'b0;
  bit dropped = 1'b0;
  bit chk_lat = 1'b1;
  int n_re, n_start, first_re, first_start, last_re, fall_cyc, err_cyc, push_cyc;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic clear_stats();
    n_re = 0; n_start = 0; first_re = -1; first_start = -1;
    last_re = -1; fall_cyc = -1; err_cyc = -1;
  endtask

  // One clock: sample outputs on the falling edge, then advance the FIFO and UART models.
  task automatic step();
    @(negedge clk);
    if (!fifo_n_re_o) begin
      n_re++;
      if (first_re < 0) first_re = cyc;
      if (fall_cyc >= 0) begin
        check("strobe_after_busy_fall", cyc - fall_cyc, GAP + 1);
        fall_cyc = -1;
      end
      last_re = cyc;
    end
    if (tx_start_o) begin
      n_start++;
      if (first_start < 0) first_start = cyc;
      if (chk_lat) check("start_after_strobe", cyc - last_re, 2);
      check("scoreboard_depth", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) check("tx_data", int'(tx_data_o), int'(exp_q.pop_front()));
      if (!stuck) rise_pend = 1'b1;
    end
    if (p_txerr_o && err_cyc < 0) err_cyc = cyc;
    if (!fifo_n_re_o && fifo_q.size() > 0) begin
      fifo_data_i = fifo_q.pop_front();
      exp_q.push_back(fifo_data_i);
    end
    if (!drop_arm) dropped = 1'b0;
    else if (model_busy) dropped = 1'b1;
    if (model_busy) begin
      busy_left--;
      if (busy_left <= 0) begin
        model_busy = 1'b0;
        fall_cyc = cyc;
      end
    end else if (rise_pend && !tx_start_o) begin
      model_busy = 1'b1;
      busy_left = busy_len;
      rise_pend = 1'b0;
    end
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_bytes_i = 16'(fifo_q.size());
    enable_i = !dropped;
    tx_busy_i = model_busy || busy_hold;
  endtask

  task automatic push_bytes(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(8'($urandom_range(1, 255)));
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_bytes_i = 16'(fifo_q.size());
  endtask

  task automatic wait_burst(input logic level, input int budget, input string name);
    int n = 0;
    while (p_burst_o !== level && n < budget) begin
      step();
      n++;
    end
    check(name, int'(p_burst_o), int'(level));
  endtask

  task automatic run_vec(input vec_t v);
    clear_stats();
    busy_len = v.busy_len;
    stuck = v.stuck;
    drop_arm = v.drop;
    chk_lat = 1'b1;
    step();
    push_bytes(v.n_bytes);
    push_cyc = cyc;
    wait_burst(1'b1, 40, "burst_start");
    wait_burst(1'b0, 3000, "burst_end");
    repeat (3) step();
    check("read_latency", first_re - push_cyc, v.lat);
    check("start_latency", first_start - push_cyc, v.lat + 2);
    check("strobe_count", n_re, v.starts);
    check("start_count", n_start, v.starts);
    check("burst_count", int'(burst_count_o), v.count);
    check("txerr", int'(p_txerr_o), v.err);
    check("fifo_left", fifo_q.size(), v.left);
    check("scoreboard_left", exp_q.size(), 0);
    if (v.err != 0) check("txerr_latency", err_cyc - first_start, ACK + 1);
    if (v.drop) begin
      drop_arm = 1'b0;
      fifo_q.delete();
      repeat (2) step();
      check("idle_after_drop", int'(p_burst_o), 0);
    end
  endtask

  // Start a burst with busy held high so the FSM parks in SEND.
  task automatic park_in_send();
    logic [7:0] exp_b;
    clear_stats();
    chk_lat = 1'b0;
    busy_hold = 1'b1;
    step();
    push_bytes(8);
    repeat (5) step();
    exp_b = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    check("send_hold_no_start", n_start, 0);
    check("send_hold_burst", int'(p_burst_o), 1);
    check("send_hold_data", int'(tx_data_o), int'(exp_b));
  endtask

  initial begin
    vecs[0] = '{8,  4,  1'b0, 1'b0, 1,  8,  8,  0, 0};
    vecs[1] = '{3,  20, 1'b0, 1'b0, 11, 3,  3,  0, 0};
    vecs[2] = '{1,  1,  1'b0, 1'b0, 11, 1,  1,  0, 0};
    vecs[3] = '{4,  20, 1'b0, 1'b1, 11, 1,  1,  0, 3};
    vecs[4] = '{10, 2,  1'b0, 1'b0, 1,  10, 10, 0, 0};
    vecs[5] = '{1,  5,  1'b1, 1'b0, 11, 1,  1,  1, 0};
    clear_stats();

    repeat (2) step();
    check("rst_n_re", int'(fifo_n_re_o), 1);
    check("rst_start", int'(tx_start_o), 0);
    check("rst_burst", int'(p_burst_o), 0);
    check("rst_txerr", int'(p_txerr_o), 0);
    check("rst_count", int'(burst_count_o), 0);
    check("rst_data", int'(tx_data_o), 0);
    rst = 1'b1;
    repeat (4) step();

    foreach (vecs[i]) run_vec(vecs[i]);

    stuck = 1'b0;
    repeat (20) step();
    check("txerr_sticky", int'(p_txerr_o), 1);
    check("idle_while_txerr", int'(p_burst_o), 0);
    n_clr_i = 1'b0;
    step();
    n_clr_i = 1'b1;
    check("txerr_cleared", int'(p_txerr_o), 0);
    check("clr_count", int'(burst_count_o), 0);

    park_in_send();
    n_clr_i = 1'b0;
    busy_hold = 1'b0;
    tx_busy_i = 1'b0;
    #1;
    check("clr_blocks_start", int'(tx_start_o), 0);
    fifo_q.delete();
    exp_q.delete();
    step();
    n_clr_i = 1'b1;
    check("clr_send_burst", int'(p_burst_o), 0);
    check("clr_send_n_re", int'(fifo_n_re_o), 1);
    check("clr_send_data", int'(tx_data_o), 0);
    check("clr_send_count", int'(burst_count_o), 0);
    check("clr_send_starts", n_start, 0);
    repeat (3) step();

    park_in_send();
    rst = 1'b0;
    busy_hold = 1'b0;
    tx_busy_i = 1'b0;
    #1;
    check("rst_send_start", int'(tx_start_o), 0);
    check("rst_send_burst", int'(p_burst_o), 0);
    check("rst_send_n_re", int'(fifo_n_re_o), 1);
    check("rst_send_data", int'(tx_data_o), 0);
    check("rst_send_count", int'(burst_count_o), 0);
    check("rst_send_txerr", int'(p_txerr_o), 0);
    fifo_q.delete();
    exp_q.delete();
    rise_pend = 1'b0;
    repeat (3) step();
    check("rst_hold_strobes", n_re, 1);
    check("rst_hold_starts", n_start, 0);
    rst = 1'b1;
    repeat (4) step();
    check("rst_release_idle", int'(p_burst_o), 0);

    run_vec(vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_fifo_scheduler.md
TX_FIFO_SCHEDULER -- requirements
Module: tx_fifo_scheduler

Interface
REQ-001 The block SHALL have parameter THRESHOLD, default 16'd8: FIFO fill level that starts a burst.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16'd1000: idle cycles with a non-empty FIFO that start a burst.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 16'd2: idle cycles inserted between consecutive bytes.
REQ-004 The block SHALL have parameter ACK_CYCLES, default 8'd8: maximum wait for tx_busy_i to rise after tx_start_o.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  reset: one clock; reset is asynchronous and active-low.
REQ-007 n_clr_i  input  1  synchronous active-low abort/clear.
REQ-008 enable_i  input  1  high permits bursts to start and continue.
REQ-009 fifo_data_i  input  8  FIFO read data, registered by the FIFO and valid the cycle after the read strobe.
REQ-010 fifo_empty_i  input  1  FIFO empty flag, active high.
REQ-011 fifo_bytes_i  input  16  FIFO fill count, unsigned.
REQ-012 tx_busy_i  input  1  UART transmitter busy, active high.
REQ-013 fifo_n_re_o  output  1  FIFO read strobe, active-low, one cycle per byte.
REQ-014 tx_data_o  output  8  byte presented to the transmitter.
REQ-015 tx_start_o  output  1  one-cycle transmit-start pulse.
REQ-016 p_burst_o  output  1  high while the state is not IDLE.
REQ-017 p_txerr_o  output  1  sticky acknowledge-timeout flag.
REQ-018 burst_count_o  output  16  bytes started in the current or last burst.

Function
REQ-019 The FSM SHALL have exactly these states: IDLE, READ, LATCH, SEND, WAIT_ACK, WAIT_DONE, GAP.
REQ-020 IDLE->READ SHALL occur when enable_i=1, fifo_empty_i=0, and either fifo_bytes_i>=THRESHOLD or idle_cnt==TIMEOUT_CYCLES.
REQ-021 idle_cnt SHALL increment in IDLE while fifo_empty_i=0, saturate at TIMEOUT_CYCLES, and clear when empty or when leaving IDLE.
REQ-022 fifo_n_re_o SHALL be 0 only in READ, for exactly one cycle, then READ->LATCH unconditionally.
REQ-023 In LATCH, tx_data_o SHALL load fifo_data_i at the clock edge, then LATCH->SEND.
REQ-024 In SEND with tx_busy_i=0, tx_start_o SHALL be 1 for that cycle, then SEND->WAIT_ACK; with tx_busy_i=1 the FSM SHALL hold in SEND and tx_start_o SHALL stay 0.
REQ-025 WAIT_ACK SHALL go to WAIT_DONE when tx_busy_i=1.
REQ-026 If tx_busy_i is not seen within ACK_CYCLES cycles in WAIT_ACK, p_txerr_o SHALL be set, the FSM SHALL go to IDLE, and the byte SHALL NOT be retried.
REQ-027 WAIT_DONE->GAP SHALL occur when tx_busy_i=0.
REQ-028 GAP SHALL last GAP_CYCLES cycles, then go to READ if enable_i=1 and fifo_empty_i=0, otherwise to IDLE.
REQ-029 With GAP_CYCLES=0, GAP SHALL last one cycle.
REQ-030 Trigger latency SHALL be: trigger true in IDLE at cycle T; fifo_n_re_o=0 at T+1; data captured at end of T+2; tx_start_o at T+3 if not busy.
REQ-031 Deasserting enable_i mid-burst SHALL complete the byte in flight, then return to IDLE from GAP.
REQ-032 burst_count_o SHALL clear on IDLE->READ, increment on each tx_start_o, and saturate at 16'hFFFF.
REQ-033 n_clr_i=0 at a clock edge SHALL force IDLE and clear idle_cnt, burst_count_o and p_txerr_o; tx_start_o SHALL be 0 in that cycle.
REQ-034 p_txerr_o SHALL otherwise clear only on reset.
REQ-035 All counters SHALL be 16-bit unsigned and never wrap.

Reset
REQ-036 rst=0 SHALL asynchronously force: state IDLE, fifo_n_re_o=1, tx_data_o=8'h00, tx_start_o=0, p_burst_o=0, p_txerr_o=0, burst_count_o=0, idle_cnt=0.
REQ-037 Reset asserted mid-burst SHALL abort immediately with no further read strobe or start pulse.
REQ-038 Release of rst SHALL be synchronous to clk.

Verification
REQ-039 The bench SHALL drive fifo_bytes_i=8, empty=0, enable=1, busy=0 -> fifo_n_re_o low 1 cycle later, tx_start_o 3 cycles later, tx_data_o equal to the FIFO byte.
REQ-040 The bench SHALL hold fifo_bytes_i=1 with TIMEOUT_CYCLES=10 -> READ entered exactly 11 cycles after the FIFO becomes non-empty.
REQ-041 The bench SHALL run a 3-byte burst, busy pulsed 20 cycles per byte, GAP_CYCLES=2 -> 3 start pulses, each read strobe exactly 3 cycles after busy falls, burst_count_o=3, return to IDLE when empty.
REQ-042 The bench SHALL keep busy stuck 0 after tx_start_o -> p_txerr_o=1 after 8 cycles, FSM in IDLE, flag held until n_clr_i=0.
REQ-043 The bench SHALL drop enable_i during WAIT_DONE -> no further read strobe, IDLE after GAP.
REQ-044 The bench SHALL assert n_clr_i=0 in SEND, and separately rst=0 in SEND -> immediate IDLE, no tx_start_o, all outputs at reset values.
